// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Reads the half-open address range [firstaddr, lastaddr) from a
//   synchronous single-port RAM (1-cycle read latency) and streams the words
//   to the convolution datapath in address order, with full backpressure.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   start                  one-cycle burst request (sampled only in IDLE)
//   firstaddr, lastaddr    range, first inclusive, last exclusive
//   re_RAM_p, re_RAM_w     RAM select (pixel has priority)
//   ram_addr, ram_re_p,
//   ram_re_w, ram_rdata    RAM read port
//   dout, dout_valid,
//   dout_ready             output stream
//   busy, done, err        status (done/err are one-cycle pulses)
//   checksum               running sum of streamed words
//   dbg_state              current FSM state, for checkers
//
// Handshake: a word transfers on a rising edge where dout_valid & dout_ready
// are both 1. Once dout_valid is raised, dout_valid and dout stay stable
// until that transfer happens; dout_valid never depends on dout_ready.
//
// Optional feature macro: BURST_CHECKSUM_EN builds the checksum
// accumulator; without it checksum is tied to 0.
module ram_burst_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] firstaddr,
  input  logic [ADDR_W-1:0] lastaddr,
  input  logic              re_RAM_p,
  input  logic              re_RAM_w,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re_p,
  output logic              ram_re_w,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_inc, last_q;
  logic              sel_p_q;
  logic              inflight;
  logic              err_q;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        occ;

  logic              pop, push, issue, credit, sel_valid, accept;

  assign sel_valid = re_RAM_p | re_RAM_w;
  assign accept    = (state == S_IDLE) && start && sel_valid;
  assign cnt_inc   = cnt + {{(ADDR_W-1){1'b0}}, 1'b1};

  assign dout_valid = (occ != 2'd0);
  assign dout       = fifo_mem[rd_ptr];
  assign pop        = dout_valid & dout_ready;
  // The read issued last cycle returns its data now.
  assign push       = inflight;

  // A new read may issue only if, after this cycle's pop and the pending
  // return land in the FIFO, one slot is still free for it.
  assign credit = (({1'b0, occ} + {2'b00, inflight}) - {2'b00, pop}) < 3'd2;
  assign issue  = (state == S_READ) && credit;

  assign ram_addr  = cnt;
  assign ram_re_p  = issue & sel_p_q;
  assign ram_re_w  = issue & ~sel_p_q;
  assign busy      = (state == S_READ) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign err       = err_q;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (lastaddr <= firstaddr) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (issue && (cnt_inc == last_q)) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the last word leaves the FIFO so done lands
        // exactly one cycle after its handshake.
        if (!inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      last_q   <= '0;
      sel_p_q  <= 1'b0;
      inflight <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      err_q    <= (state == S_IDLE) && start && !sel_valid;
      if (accept) begin
        cnt     <= firstaddr;
        last_q  <= lastaddr;
        sel_p_q <= re_RAM_p;
      end else if (issue) begin
        cnt <= cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= ram_rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= (occ + {1'b0, push}) - {1'b0, pop};
    end
  end

`ifdef BURST_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + dout;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader
//   Bench for ram_burst_reader: directed vector table, reset/abort sequence
//   and randomized bursts against a queue-based reference model.
module tb_ram_burst_reader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] firstaddr = '0;
  logic [ADDR_W-1:0] lastaddr = '0;
  logic              re_RAM_p = 1'b0;
  logic              re_RAM_w = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re_p, ram_re_w;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready = 1'b0;
  logic              busy, done, err;
  logic [DATA_W-1:0] checksum;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  ram_burst_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .firstaddr(firstaddr), .lastaddr(lastaddr),
    .re_RAM_p(re_RAM_p), .re_RAM_w(re_RAM_w),
    .ram_addr(ram_addr), .ram_re_p(ram_re_p), .ram_re_w(ram_re_w),
    .ram_rdata(ram_rdata),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done), .err(err),
    .checksum(checksum), .dbg_state(dbg_state)
  );

  typedef struct {
    int first;
    int last;
    bit p;
    bit w;
    int rmode;      // 0 ready high, 1 toggle, 2 random
    int restart_k;  // cycle of an extra (ignored) start, -1 none
    int exp_n;      // expected reads and words
    int exp_done;   // done cycle, -1 never, -2 any
    int exp_err;    // err cycle, -1 never
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- reference model state ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_rd_addr = '0;
  logic              exp_sel_p = 1'b0;
  logic [DATA_W-1:0] model_sum = '0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_dout = '0;

  function automatic logic [DATA_W-1:0] wdata(input logic [ADDR_W-1:0] a, input logic p);
    logic [DATA_W-1:0] v;
    v = DATA_W'(a);
    return p ? (v ^ 16'hA5A5) : v;
  endfunction

  function automatic void check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // RAM model: pixel and weight RAMs with distinct contents, 1-cycle latency
  always @(posedge clk) begin
    if (ram_re_p)      ram_rdata <= wdata(ram_addr, 1'b1);
    else if (ram_re_w) ram_rdata <= wdata(ram_addr, 1'b0);
    else               ram_rdata <= 16'hDEAD;
  end

  // ---------------- scoreboard and stream/read monitors ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", dout_valid, 1);
        check("hold_data", dout, prev_dout);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_extra_word: got %0h expected no word", dout);
        end else begin
          check("sb_data", dout, exp_q.pop_front());
        end
      end
      if (ram_re_p || ram_re_w) begin
        check("re_exclusive", ram_re_p & ram_re_w, 0);
        check("re_while_busy", busy, 1);
        check("re_select", ram_re_p, exp_sel_p);
        check("rd_addr", ram_addr, exp_rd_addr);
        exp_rd_addr = exp_rd_addr + 1'b1;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
    end
  end

  // ---------------- driver task ----------------
  task automatic run_burst(input vec_t v, input string tag);
    int  done_cyc = -1, err_cyc = -1, err_cnt = 0;
    int  n_re = 0, n_hs = 0, first_re = -1, first_v = -1;
    int  budget;
    bit  busy_seen = 0, busy_at_done = 0;
    bit  accepted;
    accepted = v.p || v.w;
    budget   = 6 * v.exp_n + 30;

    @(posedge clk); #1;
    firstaddr  = ADDR_W'(v.first);
    lastaddr   = ADDR_W'(v.last);
    re_RAM_p   = v.p;
    re_RAM_w   = v.w;
    start      = 1'b1;
    dout_ready = ready_for(v.rmode, 0);
    if (accepted) begin
      exp_sel_p   = v.p;
      exp_rd_addr = ADDR_W'(v.first);
      model_sum   = '0;
      for (int a = v.first; a < v.last; a++) begin
        exp_q.push_back(wdata(ADDR_W'(a), v.p));
        model_sum = model_sum + wdata(ADDR_W'(a), v.p);
      end
    end
    @(negedge clk);

    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      start = (k == v.restart_k);
      if (start) begin
        firstaddr = ADDR_W'(500);
        lastaddr  = ADDR_W'(510);
        re_RAM_p  = ~v.p;
        re_RAM_w  = 1'b1;
      end
      dout_ready = ready_for(v.rmode, k);
      @(negedge clk);
      if (ram_re_p || ram_re_w) begin
        n_re++;
        if (first_re < 0) first_re = k;
      end
      if (dout_valid && first_v < 0) first_v = k;
      if (dout_valid && dout_ready) n_hs++;
      if (busy) busy_seen = 1;
      if (err) begin
        err_cnt++;
        if (err_cyc < 0) err_cyc = k;
      end
      if (done_cyc >= 0 && k == done_cyc + 1) begin
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle_valid"}, dout_valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
        break;
      end
      if (done && done_cyc < 0) begin
        done_cyc     = k;
        busy_at_done = busy;
      end
    end
    start = 1'b0;

    check({tag, "_reads"}, n_re, v.exp_n);
    check({tag, "_words"}, n_hs, v.exp_n);
    check({tag, "_err_cycle"}, err_cyc, v.exp_err);
    check({tag, "_err_count"}, err_cnt, (v.exp_err >= 0) ? 1 : 0);
    if (v.exp_done == -2) check({tag, "_done_seen"}, done_cyc >= 0, 1);
    else                  check({tag, "_done_cycle"}, done_cyc, v.exp_done);
    if (done_cyc >= 0) check({tag, "_busy_at_done"}, busy_at_done, 0);
    if (!accepted) check({tag, "_busy_seen"}, busy_seen, 0);
    if (v.rmode == 0 && v.exp_n > 0) begin
      check({tag, "_first_re_cycle"}, first_re, 1);
      check({tag, "_first_valid_cycle"}, first_v, 3);
    end
    check({tag, "_queue_left"}, exp_q.size(), 0);
`ifdef BURST_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, model_sum);
`else
    check({tag, "_checksum"}, checksum, 0);
`endif
    exp_q.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5000000;
    n_checks++;
    n_err++;
    $display("FAIL watchdog: got timeout expected test end");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t tbl[10];
    vec_t v;
    int   n;
    bit   done_seen;

    tbl[0] = '{12, 39, 0, 1, 0, -1, 27, 30, -1};
    tbl[1] = '{228, 228, 1, 0, 0, -1, 0, 1, -1};
    tbl[2] = '{50, 40, 1, 1, 0, -1, 0, 1, -1};
    tbl[3] = '{7, 8, 1, 1, 0, -1, 1, 4, -1};
    tbl[4] = '{300, 305, 0, 0, 0, -1, 0, -1, 1};
    tbl[5] = '{100, 120, 0, 1, 0, 5, 20, 23, -1};
    tbl[6] = '{228, 228, 0, 1, 0, 1, 0, 1, -1};
    tbl[7] = '{0, 1600, 1, 0, 1, -1, 1600, -2, -1};
    tbl[8] = '{32700, 32767, 0, 1, 2, -1, 67, -2, -1};
    tbl[9] = '{40, 42, 1, 0, 1, -1, 2, -2, -1};

    // reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_re_p", ram_re_p, 0);
    check("rst_ram_re_w", ram_re_w, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_checksum", checksum, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_burst(tbl[i], $sformatf("t%0d", i));
    end

    // reset in the middle of a long pixel burst held off by dout_ready = 0
    @(posedge clk); #1;
    firstaddr   = ADDR_W'(0);
    lastaddr    = ADDR_W'(1600);
    re_RAM_p    = 1'b1;
    re_RAM_w    = 1'b0;
    start       = 1'b1;
    dout_ready  = 1'b0;
    exp_sel_p   = 1'b1;
    exp_rd_addr = '0;
    done_seen   = 0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (done) done_seen = 1;
      @(posedge clk);
    end
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", done_seen, 0);
    check("abort_ram_addr", ram_addr, 0);
    check("abort_ram_re_p", ram_re_p, 0);
    check("abort_ram_re_w", ram_re_w, 0);
    check("abort_dout", dout, 0);
    check("abort_dout_valid", dout_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_checksum", checksum, 0);
    @(posedge clk); #1;
    rst        = 1'b0;
    dout_ready = 1'b1;
    model_sum  = '0;
    exp_q.delete();
    done_seen  = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || dout_valid || busy) done_seen = 1;
      @(posedge clk);
    end
    check("abort_quiet_after", done_seen, 0);
    v = '{0, 10, 0, 1, 0, -1, 10, 13, -1};
    run_burst(v, "after_abort");

    // randomized bursts
    for (int i = 0; i < 30; i++) begin
      v.first = $urandom_range(0, 32700);
      if ($urandom_range(0, 7) == 0) v.last = v.first - ((v.first > 5) ? $urandom_range(0, 5) : 0);
      else                           v.last = v.first + $urandom_range(0, 40);
      v.p = 1'($urandom_range(0, 1));
      v.w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        v.p = 0;
        v.w = 0;
      end else if (!v.p && !v.w) begin
        v.w = 1;
      end
      v.rmode = $urandom_range(0, 2);
      n = (v.last > v.first) ? (v.last - v.first) : 0;
      if (!(v.p || v.w)) begin
        v.exp_n = 0; v.exp_done = -1; v.exp_err = 1; v.restart_k = -1;
      end else begin
        v.exp_n    = n;
        v.exp_err  = -1;
        v.exp_done = (n == 0) ? 1 : ((v.rmode == 0) ? n + 3 : -2);
        if ($urandom_range(0, 3) == 0) v.restart_k = (n == 0) ? 1 : $urandom_range(1, n + 3);
        else                           v.restart_k = -1;
      end
      run_burst(v, $sformatf("r%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Consumes the range descriptors produced by the step-indexed address decoder (first/last address plus pixel/weight read-select) and performs the actual memory reads. Walks the half-open range [firstaddr, lastaddr) against a synchronous single-port RAM with 1-cycle read latency. Streams the words to the convolution datapath over a valid/ready interface with full backpressure support. Sits between the address decoder, the pixel/weight RAMs and the DW/PW convolution engines.

## Interface

Parameters:
- DATA_W, 16, RAM word width.
- ADDR_W, 15, address width; matches the decoder's firstaddr/lastaddr.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; samples the range and select inputs.
- firstaddr  in  ADDR_W  first address, inclusive.
- lastaddr  in  ADDR_W  end address, exclusive.
- re_RAM_p  in  1  select the pixel RAM.
- re_RAM_w  in  1  select the weight RAM.
- ram_addr  out  ADDR_W  RAM read address.
- ram_re_p  out  1  pixel RAM read enable.
- ram_re_w  out  1  weight RAM read enable.
- ram_rdata  in  DATA_W  RAM read data; valid the cycle after the enable.
- dout  out  DATA_W  stream data.
- dout_valid  out  1  stream valid.
- dout_ready  in  1  stream ready from the consumer.
- busy  out  1  a burst is in progress.
- done  out  1  one-cycle pulse at the end of a burst.
- err  out  1  one-cycle pulse when start arrives with neither select set.
- checksum  out  DATA_W  running word sum (see Configuration).

## Operation

- States: IDLE, READ, DRAIN, DONE.
- **IDLE**
  - On start, latch firstaddr, lastaddr and the select. re_RAM_p has priority if both selects are set.
  - Set the address counter to firstaddr.
  - Go to READ, or to DONE if lastaddr ≤ firstaddr (empty burst, no reads issued).
  - If start arrives with neither select set: pulse err, issue no reads, stay in IDLE.
- **READ**
  - Issue one read per cycle while credit is available: the selected ram_re_* = 1, ram_addr = counter, then increment the counter.
  - Credit condition: occupancy + inflight − (dout_valid & dout_ready) < 2.
  - After issuing address lastaddr−1, go to DRAIN.
- **DRAIN**: wait until inflight = 0 and the buffer is empty, then go to DONE.
- **DONE**: pulse done for one cycle, go to IDLE.
- Output buffer:
  - 2-entry FIFO; returning ram_rdata is written the cycle after the read.
  - dout/dout_valid are driven from the FIFO head, in address order.
  - A word pops on dout_valid & dout_ready.
- busy = 1 in READ and DRAIN; 0 in IDLE and DONE.
- start while busy or in DONE is ignored.
- Address counter is ADDR_W bits. A range ending at 2^ADDR_W is not supported: lastaddr is exclusive and fits in ADDR_W bits.
- dout is held stable while dout_valid = 1 and dout_ready = 0.
- The selected ram_re_* is never asserted outside READ, and ram_re_p and ram_re_w are never both 1.

## Timing

- Reset values: ram_addr = 0, ram_re_p = ram_re_w = 0, dout = 0, dout_valid = 0, busy = 0, done = 0, err = 0, checksum = 0, state IDLE, FIFO empty, inflight cleared.
- Reset mid-burst aborts the burst. Returning data in the reset cycle is discarded, and no done is produced.
- Pipeline, with start sampled at cycle 0:
  - cycle 1: first read enable.
  - cycle 2: first ram_rdata.
  - cycle 3: first dout_valid.
- With dout_ready held high: one word per cycle, no bubbles.
- done asserts the cycle after the final word's handshake; busy is 0 in that cycle.
- Empty burst: done at cycle 1.
- Backpressure:
  - No reads issue while FIFO + inflight would exceed 2.
  - No word is ever dropped or duplicated.

## Configuration

- BURST_CHECKSUM_EN defined:
  - checksum accumulates the sum of every word handshaked on dout, modulo 2^DATA_W.
  - It clears on each accepted start and holds its value after done until the next start.
- BURST_CHECKSUM_EN undefined: checksum is tied to 0 and no accumulator logic is built.

## Test plan

- Weight burst, firstaddr = 12, lastaddr = 39, re_RAM_w = 1, ready always high, RAM returns data = addr → 27 words 12..38 on consecutive cycles from cycle 3. ram_re_p is never set. done at cycle 30. checksum = 675 when enabled.
- Pixel burst 0..1600, dout_ready toggling 1/0 every cycle → 1600 words in order, none lost or duplicated. Same-value hold on every stall.
- firstaddr = lastaddr = 228 → no read enables; done at cycle 1; dout_valid stays 0.
- start with re_RAM_p = re_RAM_w = 0 → err pulses one cycle; no reads; busy stays 0.
- rst asserted during a burst of 1600 with ready low for 10 cycles → all outputs at reset values next cycle; no done. A new burst 0..9 afterwards completes normally.
- start reasserted while busy with different addresses → ignored; original range completes unchanged.
